// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM stage of the 64-bit pipeline. Issues data-memory requests
//               with a req/ready handshake, freezes the front end (stall)
//               while a multi-cycle access is outstanding, aborts accesses
//               that exceed TIMEOUT wait cycles (sticky mem_err), resolves
//               branches (pc_src/flush/pc_target) and registers the MEM/WB
//               (_d4) results.
// Ports       : clk, rst (sync, active-low)
//               *_d3            EX/MEM pipeline register inputs
//               dmem_*          data-memory request/response handshake
//               stall, flush, pc_src, pc_target  hazard / PC control
//               mem_err         sticky timeout flag
//               *_d4            MEM/WB pipeline register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_to_reg_d3,
    input  logic            reg_write_d3,
    input  logic            branch_d3,
    input  logic            mem_read_d3,
    input  logic            mem_write_d3,
    input  logic [XLEN-1:0] pc_branch_d3,
    input  logic [XLEN-1:0] alu_result_d3,
    input  logic            alu_zero_d3,
    input  logic [XLEN-1:0] rs2_data_d3,
    input  logic [4:0]      rd_d3,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            stall,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target,
    output logic            flush,
    output logic            mem_err,
    output logic            mem_to_reg_d4,
    output logic            reg_write_d4,
    output logic [XLEN-1:0] read_data_d4,
    output logic [XLEN-1:0] alu_result_d4,
    output logic [4:0]      rd_d4
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic            r_err;

    // Access captured when the memory first withholds ready; held stable
    // on the bus for the whole WAIT period while the _d3 inputs move on.
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_mtr;
    logic            r_rw;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_alu;

    logic            r_mtr_d4;
    logic            r_rw_d4;
    logic [XLEN-1:0] r_rdata_d4;
    logic [XLEN-1:0] r_alu_d4;
    logic [4:0]      r_rd_d4;

    logic            w_acc;
    logic            w_br_taken;

    assign w_acc      = mem_read_d3 | mem_write_d3;
    // A branch that also carries an access is ignored so stall and flush
    // can never be asserted together.
    assign w_br_taken = branch_d3 & alu_zero_d3 & ~w_acc;

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        stall      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = '0;
        // Everything is forced quiet while reset is held, whatever the inputs.
        if (rst) begin
            if (r_state == S_IDLE) begin
                dmem_req   = w_acc;
                dmem_we    = mem_write_d3;
                dmem_addr  = alu_result_d3;
                dmem_wdata = rs2_data_d3;
                stall      = w_acc & ~dmem_ready;
                pc_src     = w_br_taken;
                pc_target  = w_br_taken ? pc_branch_d3 : '0;
            end else begin
                dmem_req   = 1'b1;
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                // Released on the completing and on the aborting cycle.
                stall      = ~dmem_ready & (r_cnt != C_TIMEOUT);
            end
        end
        flush = pc_src;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mtr      <= 1'b0;
            r_rw       <= 1'b0;
            r_rd       <= '0;
            r_alu      <= '0;
            r_mtr_d4   <= 1'b0;
            r_rw_d4    <= 1'b0;
            r_rdata_d4 <= '0;
            r_alu_d4   <= '0;
            r_rd_d4    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && !dmem_ready) begin
                        r_we     <= mem_write_d3;
                        r_addr   <= alu_result_d3;
                        r_wdata  <= rs2_data_d3;
                        r_mtr    <= mem_to_reg_d3;
                        r_rw     <= reg_write_d3;
                        r_rd     <= rd_d3;
                        r_alu    <= alu_result_d3;
                        r_cnt    <= 8'd1;
                        r_state  <= S_WAIT;
                        r_mtr_d4 <= 1'b0;
                        r_rw_d4  <= 1'b0;
                    end else begin
                        r_mtr_d4   <= mem_to_reg_d3;
                        r_rw_d4    <= reg_write_d3;
                        r_alu_d4   <= alu_result_d3;
                        r_rd_d4    <= rd_d3;
                        // Load data only for a pure read; writes return 0.
                        r_rdata_d4 <= (w_acc && !mem_write_d3) ? dmem_rdata : '0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready) begin
                        r_mtr_d4   <= r_mtr;
                        r_rw_d4    <= r_rw;
                        r_alu_d4   <= r_alu;
                        r_rd_d4    <= r_rd;
                        r_rdata_d4 <= r_we ? '0 : dmem_rdata;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_err    <= 1'b1;
                        r_mtr_d4 <= 1'b0;
                        r_rw_d4  <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_mtr_d4 <= 1'b0;
                        r_rw_d4  <= 1'b0;
                        r_cnt    <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_err       = r_err;
    assign mem_to_reg_d4 = r_mtr_d4;
    assign reg_write_d4  = r_rw_d4;
    assign read_data_d4  = r_rdata_d4;
    assign alu_result_d4 = r_alu_d4;
    assign rd_d4         = r_rd_d4;

endmodule
`default_nettype wire
